fmul_pipe: RTL and testbench



---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/lzc48.sv | 50 +++++
 rtl/fmul_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg -- types and constants shared by the FPU arithmetic blocks
// (divider, multiplier and later operations).
//
// Contents:
//   EXP_BIAS, EXP_MAX, QNAN_NEG : binary32 encoding constants
//   fp32_t                      : packed {sign, exponent, mantissa} view
//   fp_class_t                  : operand class (ZERO/DENORM/NORM/INF/NAN)
//   fp_classify()               : maps a binary32 word onto its class
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN_NEG = 32'hFFC0_0000;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } fp32_t;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORM,
        INF,
        NAN
    } fp_class_t;

    function automatic fp_class_t fp_classify(input fp32_t f);
        fp_class_t c;
        if (f.e == 8'd0) begin
            if (f.m == 23'd0) c = ZERO;
            else              c = DENORM;
        end else if (f.e == 8'hFF) begin
            if (f.m == 23'd0) c = INF;
            else              c = NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/lzc48.sv
// ---------------------------------------------------------------------------
// lzc48 -- combinational leading-zero counter for a 48-bit word.
//
// Ports:
//   d  in  48  word to examine (bit 47 is the most significant)
//   lz out  6  number of leading zeros; an all-zero word returns 48
//
// The word is split into six bytes; each byte reports whether it holds a
// one and where its first one sits, then the most significant non-empty
// byte selects the result.
// ---------------------------------------------------------------------------
module lzc48 (
    input  logic [47:0] d,
    output logic [5:0]  lz
);

    logic [5:0]      grp_any;
    logic [5:0][2:0] grp_lz;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_grp
            // Byte gi = 0 is the most significant byte of d.
            logic [7:0] byte_bits;
            logic [2:0] byte_lz;

            assign byte_bits = d[47-8*gi -: 8];
            assign grp_any[gi] = |byte_bits;

            // Scanning upward lets the highest set bit win.
            always_comb begin
                byte_lz = 3'd7;
                for (int i = 0; i < 8; i++) begin
                    if (byte_bits[i]) byte_lz = 3'(7 - i);
                end
            end

            assign grp_lz[gi] = byte_lz;
        end
    endgenerate

    // Scanning from the least significant byte up lets the most
    // significant non-empty byte win.
    always_comb begin
        lz = 6'd48;
        for (int g = 5; g >= 0; g--) begin
            if (grp_any[g]) lz = 6'(8 * g) + {3'd0, grp_lz[g]};
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// ---------------------------------------------------------------------------
// fmul_pipe -- three-stage pipelined IEEE-754 binary32 multiplier with a
// valid/ready handshake on both sides and an opaque routing tag.
//
// Ports:
//   clk       in   1      clock, all state changes on the rising edge
//   rst       in   1      synchronous active-high reset, drops in-flight ops
//   in_valid  in   1      operands present
//   in_ready  out  1      pipeline accepts operands this cycle
//   x1, x2    in   32     multiplicand / multiplier (binary32)
//   in_tag    in   TAG_W  tag travelling with the operands
//   out_valid out  1      result present
//   out_ready in   1      consumer takes the result
//   y         out  32     product (binary32), round-to-nearest-even
//   ovf       out  1      finite operands overflowed to infinity
//   out_tag   out  TAG_W  tag of the result
//
// Stages: S1 unpack/classify/special-case, S2 mantissa multiply,
// S3 normalize/round/pack (its register is the output register).
// The whole pipe advances together whenever the output slot is free or
// being drained, so results leave in issue order.
// ---------------------------------------------------------------------------
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    logic en;

    // ---------------- S1: unpack and classify ----------------
    fp32_t     a, b;
    fp_class_t ca, cb;
    logic      sy;
    logic      spec_next;
    logic [31:0] spec_val_next;
    logic [23:0] m1a, m2a;
    logic [7:0]  e1a, e2a;

    assign a  = x1;
    assign b  = x2;
    assign ca = fp_classify(a);
    assign cb = fp_classify(b);
    assign sy = a.s ^ b.s;

    // Denormals carry no hidden bit and sit at effective exponent 1.
    assign m1a = {(a.e != 8'd0), a.m};
    assign m2a = {(b.e != 8'd0), b.m};
    assign e1a = (a.e == 8'd0) ? 8'd1 : a.e;
    assign e2a = (b.e == 8'd0) ? 8'd1 : b.e;

    // First match wins; NaN payloads are quietened by forcing mantissa bit 22.
    always_comb begin
        spec_next     = 1'b1;
        spec_val_next = 32'd0;
        if (ca == NAN) begin
            spec_val_next = {a.s, 8'hFF, 1'b1, a.m[21:0]};
        end else if (cb == NAN) begin
            spec_val_next = {b.s, 8'hFF, 1'b1, b.m[21:0]};
        end else if ((ca == ZERO && cb == INF) || (ca == INF && cb == ZERO)) begin
            spec_val_next = QNAN_NEG;
        end else if (ca == INF || cb == INF) begin
            spec_val_next = {sy, 8'hFF, 23'd0};
        end else if (ca == ZERO || cb == ZERO) begin
            spec_val_next = {sy, 31'd0};
        end else begin
            spec_next = 1'b0;
        end
    end

    logic             v1_reg;
    logic             s1_sy_reg;
    logic             s1_spec_reg;
    logic [31:0]      s1_spec_val_reg;
    logic [23:0]      s1_m1_reg, s1_m2_reg;
    logic [7:0]       s1_e1_reg, s1_e2_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // ---------------- S2: multiply ----------------
    logic [47:0]        p_next;
    logic signed [9:0]  et_next;

    assign p_next  = {24'd0, s1_m1_reg} * {24'd0, s1_m2_reg};
    assign et_next = $signed({2'b00, s1_e1_reg}) + $signed({2'b00, s1_e2_reg})
                   - 10'sd127;

    logic               v2_reg;
    logic               s2_sy_reg;
    logic               s2_spec_reg;
    logic [31:0]        s2_spec_val_reg;
    logic [47:0]        s2_p_reg;
    logic signed [9:0]  s2_et_reg;
    logic [TAG_W-1:0]   s2_tag_reg;

    // ---------------- S3: normalize, round, pack ----------------
    logic [5:0]         lz;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  exp_base;
    logic signed [9:0]  exp_fin;
    logic [9:0]         sh;
    logic [47:0]        pn;
    logic [47:0]        pn_d;
    logic               lost;
    logic               guard;
    logic               sticky;
    logic               rnd;
    logic [24:0]        sum;
    logic [22:0]        mant;
    logic [31:0]        y_next;
    logic               ovf_next;

    lzc48 u_lzc (
        .d  (s2_p_reg),
        .lz (lz)
    );

    always_comb begin
        // Bring the leading one to bit 47 (the hidden-bit position).
        e_norm = s2_et_reg + 10'sd1 - $signed({4'd0, lz});
        pn     = s2_p_reg << lz;
        pn_d   = pn;
        lost   = 1'b0;
        sh     = 10'd0;

        // Underflow: denormalize, keeping every shifted-out bit in sticky.
        if (e_norm <= 10'sd0) begin
            sh = 10'sd1 - e_norm;
            if (sh >= 10'd48) begin
                pn_d = 48'd0;
                lost = |pn;
            end else begin
                pn_d = pn >> sh[5:0];
                lost = |(pn & ((48'd1 << sh[5:0]) - 48'd1));
            end
        end

        guard  = pn_d[23];
        sticky = (|pn_d[22:0]) | lost;
        rnd    = guard & (sticky | pn_d[24]);
        sum    = {1'b0, pn_d[47:24]} + {24'd0, rnd};

        exp_base = (e_norm <= 10'sd0) ? 10'sd0 : e_norm;
        exp_fin  = exp_base;
        mant     = sum[22:0];
        if (sum[24]) begin
            // 1.111..1 rounded up to 10.000..0
            exp_fin = exp_base + 10'sd1;
            mant    = 23'd0;
        end else if (exp_base == 10'sd0 && sum[23]) begin
            // Largest denormal rounded up into the smallest normal.
            exp_fin = 10'sd1;
        end

        ovf_next = 1'b0;
        if (s2_spec_reg) begin
            y_next = s2_spec_val_reg;
        end else if (s2_p_reg == 48'd0) begin
            y_next = {s2_sy_reg, 31'd0};
        end else if (exp_fin >= 10'sd255) begin
            // Specials were resolved in S1, so both operands are finite here.
            y_next   = {s2_sy_reg, 8'hFF, 23'd0};
            ovf_next = 1'b1;
        end else begin
            y_next = {s2_sy_reg, exp_fin[7:0], mant};
        end
    end

    logic             v3_reg;
    logic [31:0]      y_reg;
    logic             ovf_reg;
    logic [TAG_W-1:0] tag_reg;

    // ---------------- handshake ----------------
    assign en        = ~v3_reg | out_ready;
    assign in_ready  = en;
    assign out_valid = v3_reg;
    assign y         = y_reg;
    assign ovf       = ovf_reg;
    assign out_tag   = tag_reg;

    // Control and output registers (reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            v3_reg  <= 1'b0;
            y_reg   <= 32'd0;
            ovf_reg <= 1'b0;
            tag_reg <= '0;
        end else if (en) begin
            v1_reg  <= in_valid;
            v2_reg  <= v1_reg;
            v3_reg  <= v2_reg;
            y_reg   <= y_next;
            ovf_reg <= ovf_next;
            tag_reg <= s2_tag_reg;
        end
    end

    // Internal datapath registers; their contents only matter alongside a
    // set valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sy_reg       <= sy;
            s1_spec_reg     <= spec_next;
            s1_spec_val_reg <= spec_val_next;
            s1_m1_reg       <= m1a;
            s1_m2_reg       <= m2a;
            s1_e1_reg       <= e1a;
            s1_e2_reg       <= e2a;
            s1_tag_reg      <= in_tag;

            s2_sy_reg       <= s1_sy_reg;
            s2_spec_reg     <= s1_spec_reg;
            s2_spec_val_reg <= s1_spec_val_reg;
            s2_p_reg        <= p_next;
            s2_et_reg       <= et_next;
            s2_tag_reg      <= s1_tag_reg;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fmul_pipe -- scoreboard bench for fmul_pipe. The driver pushes the
// hand-computed expected result when an operation is accepted; a monitor
// pops and compares every result the DUT hands over.
// ---------------------------------------------------------------------------
module tb_fmul_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic [4:0]  out_tag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];

    fmul_pipe #(.TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compare every handed-over result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got y=%h ovf=%b tag=%0d, required no output",
                         y, ovf, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (y !== e.y || ovf !== e.ovf || out_tag !== e.tag) begin
                    fails++;
                    $display("FAIL result tag=%0d: got y=%h ovf=%b tag=%0d, required y=%h ovf=%b tag=%0d",
                             e.tag, y, ovf, out_tag, e.y, e.ovf, e.tag);
                end else begin
                    $display("[TB] result tag=%0d y=%h ovf=%b ok", out_tag, y, ovf);
                end
            end
        end
    end

    // Ready must follow the free-or-draining output slot every cycle.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            tests++;
            if (in_ready !== (!out_valid || out_ready)) begin
                fails++;
                $display("FAIL in_ready: got %b, required %b (out_valid=%b out_ready=%b)",
                         in_ready, (!out_valid || out_ready), out_valid, out_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Present one operation (caller sits just after a rising edge) and keep
    // it up until accepted; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] ey, input logic eo);
        exp_t e;
        int   k;
        x1       = a;
        x2       = b;
        in_tag   = t;
        in_valid = 1'b1;
        k        = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout tag=%0d: got in_ready=0, required 1 within 100 cycles", t);
        end else begin
            e.y   = ey;
            e.ovf = eo;
            e.tag = t;
            exp_q.push_back(e);
            $display("[TB] issue tag=%0d x1=%h x2=%h expect y=%h ovf=%b", t, a, b, ey, eo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x1        = 32'd0;
        x2        = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset state (inputs presented during reset must be ignored).
        in_valid = 1'b1;
        x1       = 32'h4000_0000;
        x2       = 32'h4000_0000;
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y",         y,                  32'd0);
        check("reset_ovf",       {31'd0, ovf},       32'd0);
        check("reset_out_tag",   {27'd0, out_tag},   32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        step();

        // 1: basic product and latency.
        issue(32'h4000_0000, 32'h4040_0000, 5'd1, 32'h40C0_0000, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c3", {31'd0, out_valid}, 32'd1);
        step();
        drain();

        // 2: rounding; 3: overflow; 4: specials; 5: denormals (back to back).
        issue(32'h3F80_0001, 32'h3F80_0001, 5'd2,  32'h3F80_0002, 1'b0);
        issue(32'h3F80_0000, 32'h3F80_0000, 5'd3,  32'h3F80_0000, 1'b0);
        issue(32'h7F00_0000, 32'h4000_0000, 5'd4,  32'h7F80_0000, 1'b1);
        issue(32'hFF00_0000, 32'h4000_0000, 5'd5,  32'hFF80_0000, 1'b1);
        issue(32'h0000_0000, 32'h7F80_0000, 5'd6,  32'hFFC0_0000, 1'b0);
        issue(32'h7F80_0001, 32'h3F80_0000, 5'd7,  32'h7FC0_0001, 1'b0);
        issue(32'h3F80_0000, 32'hFFC0_0002, 5'd8,  32'hFFC0_0002, 1'b0);
        issue(32'h8000_0000, 32'h4000_0000, 5'd9,  32'h8000_0000, 1'b0);
        issue(32'h0080_0000, 32'h3F00_0000, 5'd10, 32'h0040_0000, 1'b0);
        issue(32'h0000_0001, 32'h3F00_0000, 5'd11, 32'h0000_0000, 1'b0);
        issue(32'h0000_0003, 32'h3F00_0000, 5'd12, 32'h0000_0002, 1'b0);
        issue(32'h4040_0000, 32'h4040_0000, 5'd13, 32'h4110_0000, 1'b0);
        drain();

        // 6: back-pressure -- five ops while the consumer stalls 4 cycles.
        out_ready = 1'b0;
        fork
            begin
                issue(32'h3F80_0000, 32'h4000_0000, 5'd14, 32'h4000_0000, 1'b0);
                issue(32'h4000_0000, 32'h4040_0000, 5'd15, 32'h40C0_0000, 1'b0);
                issue(32'h3F80_0000, 32'h3F00_0000, 5'd16, 32'h3F00_0000, 1'b0);
                issue(32'h4040_0000, 32'h4040_0000, 5'd17, 32'h4110_0000, 1'b0);
                issue(32'h4080_0000, 32'h3F00_0000, 5'd18, 32'h4000_0000, 1'b0);
                in_valid = 1'b0;
            end
            begin
                k = 0;
                while (!out_valid && k < 20) begin
                    step();
                    k++;
                end
                check("stall_first_valid", {31'd0, out_valid}, 32'd1);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_hold_tag", {27'd0, out_tag}, 32'd14);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight: both must vanish.
        issue(32'h4000_0000, 32'h4000_0000, 5'd20, 32'h4080_0000, 1'b0);
        issue(32'h4040_0000, 32'h4000_0000, 5'd21, 32'h40C0_0000, 1'b0);
        x1     = 32'h3F80_0000;
        x2     = 32'h3F80_0000;
        in_tag = 5'd22;
        rst    = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (8) step();
        check("rst_flush_final_valid", {31'd0, out_valid}, 32'd0);

        // Pipe still works after the mid-flight reset.
        issue(32'h4000_0000, 32'h4040_0000, 5'd23, 32'h40C0_0000, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
